// File: rtl/framebuffer_writer_if.sv
// Pixel-in stream and framebuffer write port of the framebuffer writer.
// Also provides the shared color / fixed-point coordinate types.
`ifndef COLOR_BITS
`define COLOR_BITS 8
`endif
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif
`ifndef FX_FRAC_BITS
`define FX_FRAC_BITS 4
`endif

typedef struct packed {
  logic signed [`FX_TOTAL_BITS-1:0] x;
  logic signed [`FX_TOTAL_BITS-1:0] y;
} coord_2d_t;

interface framebuffer_writer_if #(parameter int ADDR_BITS = 17);
  logic                   vld_in;
  logic                   rdy_in;
  logic [`COLOR_BITS-1:0] color_in;
  coord_2d_t              pixel_in;
  logic                   mem_we;
  logic                   mem_rdy;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [`COLOR_BITS-1:0] mem_wdata;

  modport master (output vld_in, color_in, pixel_in, mem_rdy,
                  input  rdy_in, mem_we, mem_addr, mem_wdata);
  modport slave  (input  vld_in, color_in, pixel_in, mem_rdy,
                  output rdy_in, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/framebuffer_writer.sv
// Buffers flushed pixels, converts fixed-point coordinates to linear addresses,
// drops off-screen pixels and performs an ordered full-frame clear sweep.
module framebuffer_writer #(
  parameter int                     FB_WIDTH    = 320,
  parameter int                     FB_HEIGHT   = 240,
  parameter int                     FIFO_DEPTH  = 4,
  parameter logic [`COLOR_BITS-1:0] CLEAR_COLOR = '0,
  parameter int                     ADDR_BITS   = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  framebuffer_writer_if.slave  bus,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [31:0]          pixel_count,
  output logic [31:0]          drop_count
);
  localparam int CB    = `COLOR_BITS;
  localparam int FXT   = `FX_TOTAL_BITS;
  localparam int FXF   = `FX_FRAC_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FB_WIDTH*FB_HEIGHT-1);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic [CB-1:0] color;
    coord_2d_t     pixel;
  } pix_t;

  pix_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [0:0]       state;
  logic             clear_pend;
  logic             out_we;
  logic [ADDR_BITS-1:0] out_addr;
  logic [CB-1:0]    out_wdata;

  logic fifo_full, fifo_empty, push, pop, out_free, off_screen, start_clear;
  pix_t head;
  logic signed [31:0] xi, yi;

  assign fifo_full  = fifo_cnt == (PTR_W+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign bus.rdy_in = !fifo_full && state == ST_RUN && !clear_pend;
  assign push       = bus.vld_in && bus.rdy_in;
  assign out_free   = !out_we || bus.mem_rdy;
  assign pop        = out_free && !fifo_empty && state == ST_RUN;
  assign head       = fifo_q[rd_ptr];

  // Sign-extend before the arithmetic shift so negative coordinates floor toward -inf.
  assign xi = $signed({{(32-FXT){head.pixel.x[FXT-1]}}, head.pixel.x}) >>> FXF;
  assign yi = $signed({{(32-FXT){head.pixel.y[FXT-1]}}, head.pixel.y}) >>> FXF;
  assign off_screen = xi < 0 || yi < 0 || xi >= FB_WIDTH || yi >= FB_HEIGHT;

  // Clear waits until every earlier pixel has left the output register.
  assign start_clear = state == ST_RUN && clear_pend && fifo_empty && out_free;
  assign clear_busy  = clear_pend || state == ST_CLEAR;

  assign bus.mem_we    = out_we;
  assign bus.mem_addr  = out_addr;
  assign bus.mem_wdata = out_wdata;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= {bus.color_in, bus.pixel_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      clear_pend  <= 1'b0;
      clear_done  <= 1'b0;
      out_we      <= 1'b0;
      out_addr    <= '0;
      out_wdata   <= '0;
      pixel_count <= '0;
      drop_count  <= '0;
    end else begin
      clear_done <= 1'b0;
      if (clear_req && state == ST_RUN && !clear_pend) clear_pend <= 1'b1;
      case (state)
        ST_RUN: begin
          if (start_clear) begin
            state      <= ST_CLEAR;
            clear_pend <= 1'b0;
            out_we     <= 1'b1;
            out_addr   <= '0;
            out_wdata  <= CLEAR_COLOR;
          end else if (pop && !off_screen) begin
            out_we    <= 1'b1;
            out_addr  <= ADDR_BITS'(yi * FB_WIDTH + xi);
            out_wdata <= head.color;
            if (pixel_count != '1) pixel_count <= pixel_count + 1'b1;
          end else begin
            if (out_free) out_we <= 1'b0;
            if (pop && drop_count != '1) drop_count <= drop_count + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (bus.mem_rdy) begin
            if (out_addr == LAST_ADDR) begin
              state      <= ST_RUN;
              out_we     <= 1'b0;
              clear_done <= 1'b1;
            end else begin
              out_addr <= out_addr + 1'b1;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: vector table plus stall, clear and reset sequences.
module tb_framebuffer_writer;
  localparam int W = 320, H = 240, NPIX = W*H;
  localparam int FXT = `FX_TOTAL_BITS;
  localparam logic [7:0] CC = 8'h3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_req = 1'b0;
  logic clear_busy, clear_done;
  logic [31:0] pixel_count, drop_count;

  framebuffer_writer_if #(.ADDR_BITS(17)) bus();

  framebuffer_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(4), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear_req(clear_req), .clear_busy(clear_busy),
    .clear_done(clear_done), .pixel_count(pixel_count), .drop_count(drop_count));

  always #5 clk = ~clk;

  typedef struct { int x16; int y16; logic [7:0] color; bit drop; int addr; } vec_t;
  typedef struct { int addr; logic [7:0] color; } wr_t;

  vec_t vecs[11];
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   tests = 0, fails = 0;
  int   clr_exp = 0, exp_pix = 0, exp_drop = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int x16, input int y16, input logic [7:0] c);
    coord_2d_t p;
    p.x = FXT'(x16);
    p.y = FXT'(y16);
    bus.pixel_in = p;
    bus.color_in = c;
    bus.vld_in   = 1'b1;
  endtask

  // Every accepted write is matched against pending pixels first, then the clear sweep.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (clear_busy) chk("rdy_in_during_clear", {31'd0, bus.rdy_in}, 0);
      if (bus.mem_we && bus.mem_rdy) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {15'd0, bus.mem_addr}, mon_e.addr);
          chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, mon_e.color});
        end else if (clear_busy) begin
          chk("clr_addr", {15'd0, bus.mem_addr}, clr_exp);
          chk("clr_data", {24'd0, bus.mem_wdata}, {24'd0, CC});
          clr_exp++;
        end else begin
          chk("unexpected_write", {31'd0, bus.mem_we}, 0);
        end
      end
    end
  end

  initial begin
    int k, cnt;
    bit ok;
    vecs[0]  = '{80,   48,   8'hA5, 1'b0, 965};
    vecs[1]  = '{-16,  0,    8'h01, 1'b1, 0};
    vecs[2]  = '{5120, 0,    8'h02, 1'b1, 0};
    vecs[3]  = '{0,    3840, 8'h03, 1'b1, 0};
    vecs[4]  = '{5116, 3832, 8'h5A, 1'b0, 76799};
    vecs[5]  = '{8,    4,    8'h11, 1'b0, 0};
    vecs[6]  = '{-4,   160,  8'h04, 1'b1, 0};
    vecs[7]  = '{127,  16,   8'h33, 1'b0, 327};
    vecs[8]  = '{0,    -1,   8'h05, 1'b1, 0};
    vecs[9]  = '{5104, 3824, 8'h77, 1'b0, 76799};
    vecs[10] = '{1600, 1600, 8'hC3, 1'b0, 32100};

    bus.vld_in = 1'b0; bus.color_in = '0; bus.pixel_in = '0; bus.mem_rdy = 1'b1;
    #12;
    chk("rst_rdy_in", {31'd0, bus.rdy_in}, 1);
    chk("rst_clear_busy", {31'd0, clear_busy}, 0);
    chk("rst_clear_done", {31'd0, clear_done}, 0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 0);
    chk("rst_mem_addr", {15'd0, bus.mem_addr}, 0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 0);
    chk("rst_pixel_count", pixel_count, 0);
    chk("rst_drop_count", drop_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    // Table: single pixels through an empty pipeline.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].x16, vecs[i].y16, vecs[i].color);
      chk("vec_rdy", {31'd0, bus.rdy_in}, 1);
      if (!vecs[i].drop) exp_q.push_back('{vecs[i].addr, vecs[i].color});
      tick();
      bus.vld_in = 1'b0;
      chk("vec_latency_we", {31'd0, bus.mem_we}, 0);
      tick();
      if (vecs[i].drop) begin
        exp_drop++;
        chk("vec_drop_we", {31'd0, bus.mem_we}, 0);
        chk("vec_drop_count", drop_count, exp_drop);
      end else begin
        exp_pix++;
        chk("vec_we", {31'd0, bus.mem_we}, 1);
        chk("vec_addr", {15'd0, bus.mem_addr}, vecs[i].addr);
        chk("vec_data", {24'd0, bus.mem_wdata}, {24'd0, vecs[i].color});
        chk("vec_pixel_count", pixel_count, exp_pix);
      end
      tick();
    end

    // Stream of 100 pixels at full rate.
    for (int i = 0; i < 100; i++) begin
      drive(i*3*16, i*16, 8'(i));
      chk("stream_rdy", {31'd0, bus.rdy_in}, 1);
      exp_q.push_back('{i*323, 8'(i)});
      tick();
      if (i > 0) chk("stream_we", {31'd0, bus.mem_we}, 1);
    end
    bus.vld_in = 1'b0;
    tick();
    chk("stream_we_last", {31'd0, bus.mem_we}, 1);
    tick();
    chk("stream_we_end", {31'd0, bus.mem_we}, 0);
    exp_pix += 100;
    chk("stream_pixel_count", pixel_count, exp_pix);
    chk("stream_q_empty", exp_q.size(), 0);

    // Stall: memory back-pressure for 20 cycles.
    bus.mem_rdy = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      drive(160 + k*16, 800, 8'hC0 + 8'(k));
      ok = bus.rdy_in;
      tick();
      if (ok) begin
        exp_q.push_back('{16010 + k, 8'hC0 + 8'(k)});
        k++;
      end
      if (c >= 1) begin
        chk("stall_hold_we", {31'd0, bus.mem_we}, 1);
        chk("stall_hold_addr", {15'd0, bus.mem_addr}, 16010);
        chk("stall_hold_data", {24'd0, bus.mem_wdata}, 32'hC0);
      end
    end
    chk("stall_transfers", k, 5);
    chk("stall_rdy_low", {31'd0, bus.rdy_in}, 0);
    bus.vld_in = 1'b0;
    bus.mem_rdy = 1'b1;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 50) begin tick(); cnt++; end
    chk("stall_drain_q", exp_q.size(), 0);
    tick();
    chk("stall_drain_we", {31'd0, bus.mem_we}, 0);
    exp_pix += 5;
    chk("stall_pixel_count", pixel_count, exp_pix);

    // Clear ordered behind 3 buffered pixels plus one accepted with the request.
    bus.mem_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive((200 + j)*16, 0, 8'h90 + 8'(j));
      chk("clr_pre_rdy", {31'd0, bus.rdy_in}, 1);
      exp_q.push_back('{200 + j, 8'h90 + 8'(j)});
      tick();
    end
    drive(203*16, 0, 8'h93);
    clear_req = 1'b1;
    chk("clr_req_rdy", {31'd0, bus.rdy_in}, 1);
    exp_q.push_back('{203, 8'h93});
    tick();
    clear_req = 1'b0;
    bus.vld_in = 1'b0;
    chk("clr_busy_set", {31'd0, clear_busy}, 1);
    chk("clr_rdy_low", {31'd0, bus.rdy_in}, 0);
    clr_exp = 0;
    bus.mem_rdy = 1'b1;
    cnt = 0;
    while (!clear_done && cnt < 80000) begin tick(); cnt++; end
    chk("clr_done_seen", {31'd0, clear_done}, 1);
    chk("clr_write_count", clr_exp, NPIX);
    chk("clr_pixels_first", exp_q.size(), 0);
    chk("clr_busy_end", {31'd0, clear_busy}, 0);
    chk("clr_we_end", {31'd0, bus.mem_we}, 0);
    exp_pix += 4;
    chk("clr_pixel_count", pixel_count, exp_pix);
    chk("clr_drop_count", drop_count, exp_drop);
    tick();
    chk("clr_done_pulse", {31'd0, clear_done}, 0);
    chk("clr_rdy_back", {31'd0, bus.rdy_in}, 1);

    // Asynchronous reset in the middle of a clear sweep.
    clr_exp = 0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (!(bus.mem_addr == 17'd1000 && clear_busy) && cnt < 2000) begin tick(); cnt++; end
    chk("rstmid_reached_1000", {15'd0, bus.mem_addr}, 1000);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_we", {31'd0, bus.mem_we}, 0);
    chk("rstmid_addr", {15'd0, bus.mem_addr}, 0);
    chk("rstmid_pixel_count", pixel_count, 0);
    chk("rstmid_drop_count", drop_count, 0);
    chk("rstmid_busy", {31'd0, clear_busy}, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rstmid_rdy_after", {31'd0, bus.rdy_in}, 1);
    drive(32, 16, 8'hE1);
    exp_q.push_back('{322, 8'hE1});
    tick();
    bus.vld_in = 1'b0;
    tick();
    chk("rstmid_run_we", {31'd0, bus.mem_we}, 1);
    chk("rstmid_run_addr", {15'd0, bus.mem_addr}, 322);
    tick();
    chk("rstmid_run_count", pixel_count, 1);
    chk("rstmid_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
